multicycle_control_fsm: RTL

Main controller for the multicycle datapath. Sequences each instruction through fetch/decode/execute states and issues datapath enables and mux selects. Its unconditioned write and flag requests (`FlagW`, `PCS`, `Register_Wr`, `Memory_Wr`, `NoWrite`) feed the condition-logic stage, which gates them with `CondEx`. That stage returns nothing to this block: the FSM never sees the condition result.

---
 rtl/multicycle_control_fsm_pkg.sv | 45 ++++
 rtl/multicycle_control_fsm_alu_decoder.sv | 44 ++++
 rtl/multicycle_control_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle controller and datapath muxes.
// Holds the state enum, ALUOp/cmd constants and mux select codes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic ALUOP_NONE = 1'b0;
   localparam logic ALUOP_DP   = 1'b1;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder: (ALUOp, Funct) to ALU control,
// flag-write requests and the CMP/unsupported write suppress.
module alu_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic       alu_op_i,
   input  logic [4:0] funct_i,
   output logic [1:0] alu_ctl_o,
   output logic [1:0] flag_w_o,
   output logic       no_write_o
);

   logic supported;
   logic s_bit;

   assign s_bit = funct_i[0];

   always_comb begin
      alu_ctl_o  = ALU_ADD;
      flag_w_o   = 2'b00;
      no_write_o = 1'b0;
      supported  = 1'b1;
      if (alu_op_i == ALUOP_DP) begin
         unique case (funct_i[4:1])
            CMD_ADD: alu_ctl_o = ALU_ADD;
            CMD_SUB: alu_ctl_o = ALU_SUB;
            CMD_AND: alu_ctl_o = ALU_AND;
            CMD_ORR: alu_ctl_o = ALU_ORR;
            CMD_CMP: begin
               alu_ctl_o  = ALU_SUB;
               no_write_o = 1'b1;
            end
            default: begin
               supported  = 1'b0;
               no_write_o = 1'b1;
            end
         endcase
         // Carry/overflow only make sense for the adder ops.
         if (supported)
            flag_w_o = {s_bit, s_bit & ~alu_ctl_o[1]};
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle controller: sequences fetch/decode/execute and
// issues datapath enables, mux selects and write requests.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] FlagW,
   output logic       PCS,
   output logic       Register_Wr,
   output logic       Memory_Wr,
   output logic       NoWrite,
   output logic       InstrDone
);

   state_t state_q;
   state_t state_d;
   logic   alu_op;
   logic   branch;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      IRWrite     = 1'b0;
      NextPC      = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ResultSrc   = RES_ALUOUT;
      alu_op      = ALUOP_NONE;
      branch      = 1'b0;
      Register_Wr = 1'b0;
      Memory_Wr   = 1'b0;
      InstrDone   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            unique case (Op)
               OP_MEM: state_d = S_MEMADR;
               OP_DP:  state_d = Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:  state_d = S_BRANCH;
               OP_UNDEF: begin
                  state_d   = S_FETCH;
                  InstrDone = 1'b1;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = SRCB_IMM;
            state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc   = RES_DATA;
            Register_Wr = 1'b1;
            InstrDone   = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc    = 1'b1;
            Memory_Wr = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXECR: begin
            alu_op  = ALUOP_DP;
            ALUSrcB = SRCB_REG;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            alu_op  = ALUOP_DP;
            ALUSrcB = SRCB_IMM;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            Register_Wr = 1'b1;
            InstrDone   = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            branch    = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign PCS = branch | (Register_Wr & (Rd == 4'hF));

   alu_decoder u_alu_decoder (
      .alu_op_i   (alu_op),
      .funct_i    (Funct[4:0]),
      .alu_ctl_o  (ALUControl),
      .flag_w_o   (FlagW),
      .no_write_o (NoWrite)
   );

endmodule
